// File: rtl/tc_abuffer_ctrl.sv
// tc_abuffer_ctrl: sequencer for the tensor-core A-tile buffer.
// Loads ITER_M*ITER_K A tiles from tile memory into buffer slots, then
// streams slots to the datapath in m (outer), n (middle), k (inner) order.
// Tile data goes straight from memory to the buffer. This block only
// drives the buffer's write enable and slot pointers.
module tc_abuffer_ctrl #(
    parameter int ITER_M = 4,
    parameter int ITER_K = 4,
    parameter int DW_IDX = 4,
    parameter int AW     = 16,
    parameter int NW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     cfg_base,
    input  logic [NW-1:0]     cfg_iter_n,
    output logic              mem_req,
    output logic [AW-1:0]     mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              buf_we,
    output logic [DW_IDX-1:0] buf_ptr_in,
    output logic [DW_IDX-1:0] buf_ptr_out,
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic              tile_k_first,
    output logic              tile_k_last,
    output logic              busy,
    output logic              done
);

    localparam int T  = ITER_M * ITER_K;
    localparam int CW = $clog2(T + 1);
    localparam int MW = (ITER_M > 1) ? $clog2(ITER_M) : 1;
    localparam int KW = (ITER_K > 1) ? $clog2(ITER_K) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     base_q;
    logic [NW-1:0]     iter_n_q;
    logic [CW-1:0]     issue_cnt, ret_cnt;
    logic [MW-1:0]     m_q, m_nxt;
    logic [NW-1:0]     n_q, n_nxt;
    logic [KW-1:0]     k_q, k_nxt;
    logic [DW_IDX-1:0] ptr_out_q, ptr_nxt;

    logic job_start, issue_open, wr, last_wr, hs;
    logic last_k, last_n, last_m, fin;

    assign job_start  = (state == S_IDLE) & start;
    assign issue_open = issue_cnt < CW'(T);
    // A return after all T slots are filled is a protocol error and is dropped.
    assign wr         = (state == S_LOAD) & mem_rvalid & (ret_cnt < CW'(T));
    assign last_wr    = wr & (ret_cnt == CW'(T - 1));
    assign hs         = (state == S_STREAM) & tile_ready;

    assign last_k = (k_q == KW'(ITER_K - 1));
    assign last_n = (n_q == iter_n_q - NW'(1));
    assign last_m = (m_q == MW'(ITER_M - 1));
    assign fin    = hs & last_k & last_n & last_m;

    // Address and write slot are zero whenever they are not being used.
    assign mem_addr     = mem_req ? (base_q + AW'(issue_cnt)) : '0;
    assign buf_ptr_in   = buf_we ? DW_IDX'(ret_cnt) : '0;
    assign buf_ptr_out  = ptr_out_q;
    assign tile_k_first = tile_valid & (k_q == '0);
    assign tile_k_last  = tile_valid & last_k;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and FSM-owned outputs.
    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        buf_we     = 1'b0;
        tile_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                mem_req = issue_open;
                buf_we  = wr;
                if (last_wr) state_nxt = (iter_n_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                tile_valid = 1'b1;
                if (fin) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // k/n/m step with carries; the final handshake wraps everything to 0.
    always_comb begin
        k_nxt   = last_k ? '0 : k_q + KW'(1);
        n_nxt   = n_q;
        m_nxt   = m_q;
        if (last_k) n_nxt = last_n ? '0 : n_q + NW'(1);
        if (last_k & last_n) m_nxt = last_m ? '0 : m_q + MW'(1);
        ptr_nxt = DW_IDX'(m_nxt) * DW_IDX'(ITER_K) + DW_IDX'(k_nxt);
    end

    // Job config latch, issue/return counters and stream position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            iter_n_q  <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            ptr_out_q <= '0;
        end else begin
            if (job_start) begin
                base_q    <= cfg_base;
                iter_n_q  <= cfg_iter_n;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                m_q       <= '0;
                n_q       <= '0;
                k_q       <= '0;
                ptr_out_q <= '0;
            end
            if (mem_req & mem_gnt) issue_cnt <= issue_cnt + CW'(1);
            if (wr)                ret_cnt   <= ret_cnt + CW'(1);
            // Pointer is registered so A_tile is valid alongside tile_valid.
            if (hs) begin
                k_q       <= k_nxt;
                n_q       <= n_nxt;
                m_q       <= m_nxt;
                ptr_out_q <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_tc_abuffer_ctrl.sv
// Directed bench for tc_abuffer_ctrl: memory model with grant stalls and
// in-order returns, a cycle monitor that tallies sequence errors, and a
// main sequence that checks tallies and boundary behaviour.
module tb_tc_abuffer_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [7:0]  cfg_iter_n = '0;
    logic        mem_req, buf_we, tile_valid, tile_k_first, tile_k_last, busy, done;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        tile_ready = 1'b0;
    logic [3:0]  buf_ptr_in, buf_ptr_out;

    tc_abuffer_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base),
        .cfg_iter_n(cfg_iter_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .buf_we(buf_we),
        .buf_ptr_in(buf_ptr_in), .buf_ptr_out(buf_ptr_out),
        .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_k_first(tile_k_first), .tile_k_last(tile_k_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Mode knobs (written by main only).
    int lat = 1;
    bit stall_en = 1'b0;
    bit rdy_rand = 1'b0;

    // Monitor tallies (written by monitor only).
    int cyc, n_wr, n_iss, n_hs, n_tv, n_done, n_klast, last_wr_cyc, done_cyc;
    int bad_addr, bad_wr, bad_ptr, bad_flag, bad_hold, bad_order, bad_busy, bad_stall;
    logic [15:0] mon_base;
    int          mon_itn;
    bit          p_stall, p_hold, p_done, p_lastwr;
    logic [15:0] p_addr;
    logic [5:0]  p_out;
    int          due_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        n_wr = 0; n_iss = 0; n_hs = 0; n_tv = 0; n_done = 0; n_klast = 0;
        last_wr_cyc = 0; done_cyc = 0;
        bad_addr = 0; bad_wr = 0; bad_ptr = 0; bad_flag = 0; bad_hold = 0;
        bad_order = 0; bad_busy = 0; bad_stall = 0;
    endtask

    // Memory/datapath model at negedge, then sample DUT 1ns later.
    always @(negedge clk) begin
        int kk, rr, ee;
        cyc++;
        if (reset) begin
            due_q.delete();
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
        end else begin
            mem_rvalid = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                mem_rvalid = 1'b1;
                void'(due_q.pop_front());
            end
            mem_gnt = mem_req && (!stall_en || $urandom_range(0, 2) != 0);
            if (mem_gnt) due_q.push_back(cyc + lat);
        end
        tile_ready = !rdy_rand || ($urandom_range(0, 1) == 1);
        #1;
        if (reset) begin
            mon_clear();
        end else if (start && !busy) begin
            mon_clear();
            mon_base = cfg_base;
            mon_itn  = int'(cfg_iter_n);
        end else begin
            if (mem_req && p_stall && mem_addr != p_addr) bad_stall++;
            if (mem_req && mem_gnt) begin
                if (mem_addr != 16'(int'(mon_base) + n_iss)) bad_addr++;
                n_iss++;
            end
            if (buf_we) begin
                if (buf_ptr_in != 4'(n_wr)) bad_wr++;
                n_wr++;
                last_wr_cyc = cyc;
            end
            if (tile_valid) begin
                n_tv++;
                if (n_wr != T) bad_order++;
                if (p_hold && {buf_ptr_out, tile_k_first, tile_k_last} != p_out) bad_hold++;
                if (tile_ready && mon_itn != 0) begin
                    kk = n_hs % 4;
                    rr = n_hs / 4;
                    ee = (rr / mon_itn) * 4 + kk;
                    if (int'(buf_ptr_out) != ee) bad_ptr++;
                    if (tile_k_first != (kk == 0) || tile_k_last != (kk == 3)) bad_flag++;
                    if (tile_k_last) n_klast++;
                    n_hs++;
                end
            end else if (p_hold) bad_hold++;
            if (p_lastwr && mon_itn != 0 && !tile_valid) bad_order++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (p_done && busy) bad_busy++;
        end
        p_stall  = mem_req && !mem_gnt;
        p_addr   = mem_addr;
        p_hold   = tile_valid && !tile_ready;
        p_out    = {buf_ptr_out, tile_k_first, tile_k_last};
        p_done   = done;
        p_lastwr = buf_we && buf_ptr_in == 4'd15;
    end

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_req"},   int'(mem_req), 0);
        chk({nm, "_we"},    int'(buf_we), 0);
        chk({nm, "_tv"},    int'(tile_valid), 0);
        chk({nm, "_kf_kl"}, int'({tile_k_first, tile_k_last}), 0);
        chk({nm, "_busy"},  int'(busy), 0);
        chk({nm, "_done"},  int'(done), 0);
        chk({nm, "_addr"},  int'(mem_addr), 0);
        chk({nm, "_pin"},   int'(buf_ptr_in), 0);
        chk({nm, "_pout"},  int'(buf_ptr_out), 0);
    endtask

    task automatic start_job(input logic [15:0] base, input logic [7:0] itn);
        @(negedge clk);
        cfg_base = base; cfg_iter_n = itn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Later cfg changes must not reach the running job.
        cfg_base = 16'hF000; cfg_iter_n = 8'd7;
        #2;
        chk("req_rise", int'(mem_req), 1);
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_done_and_check(input string nm, input int exp_hs);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (n_done > 0) break;
        end
        chk({nm, "_done_seen"}, n_done, 1);
        @(negedge clk); #2;
        chk({nm, "_busy_fall"}, int'(busy), 0);
        chk({nm, "_done_pulse"}, int'(done), 0);
        repeat (3) @(negedge clk);
        #2;
        chk({nm, "_done_once"}, n_done, 1);
        chk({nm, "_issues"}, n_iss, T);
        chk({nm, "_writes"}, n_wr, T);
        chk({nm, "_handshakes"}, n_hs, exp_hs);
        chk({nm, "_klast"}, n_klast, exp_hs / 4);
        chk({nm, "_bad_addr"}, bad_addr, 0);
        chk({nm, "_bad_wr_slot"}, bad_wr, 0);
        chk({nm, "_bad_ptr_out"}, bad_ptr, 0);
        chk({nm, "_bad_kflags"}, bad_flag, 0);
        chk({nm, "_bad_hold"}, bad_hold, 0);
        chk({nm, "_bad_order"}, bad_order, 0);
        chk({nm, "_bad_stall"}, bad_stall, 0);
        chk({nm, "_bad_busy"}, bad_busy, 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        #2;
        chk_idle_outputs("rst_held");
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk_idle_outputs("rst_rel");

        // Basic job: 16 tiles, one pass, ready always high.
        start_job(16'h0040, 8'd1);
        wait_done_and_check("j1", 16);
        chk("j1_stream_cycles", n_tv, 16);
        chk("j1_done_lag", done_cyc - last_wr_cyc, 17);

        // Two N blocks: each A row streamed twice.
        start_job(16'h0100, 8'd2);
        wait_done_and_check("j2", 32);
        chk("j2_stream_cycles", n_tv, 32);

        // Grant stalls, 3 outstanding reads, random ready.
        stall_en = 1'b1; lat = 3; rdy_rand = 1'b1;
        start_job(16'h0200, 8'd3);
        wait_done_and_check("j3", 48);
        stall_en = 1'b0; lat = 1; rdy_rand = 1'b0;

        // Zero N blocks: load only, done right after the last write.
        start_job(16'h0300, 8'd0);
        wait_done_and_check("j4", 0);
        chk("j4_no_tv", n_tv, 0);
        chk("j4_done_lag", done_cyc - last_wr_cyc, 1);

        // Reset at the 7th buffer write aborts the job.
        start_job(16'h0020, 8'd1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (buf_we && buf_ptr_in == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_w7_found", int'(found), 1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        chk("rst_no_wr", n_wr, 0);
        chk("rst_no_tv", n_tv, 0);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle", int'(busy), 0);
        start_job(16'h0080, 8'd1);
        wait_done_and_check("j5", 16);

        // start during STREAM is ignored.
        start_job(16'h0010, 8'd1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #2;
            if (n_hs >= 5) break;
        end
        chk("j6_streaming", int'(tile_valid), 1);
        @(negedge clk);
        cfg_base = 16'h0990; cfg_iter_n = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done_and_check("j6", 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tc_abuffer_ctrl.md
# tc_Abuffer_ctrl

Sequencer for the tensor-core A-tile buffer (`tc_Abuffer`). On `start` it fetches all `ITER_M*ITER_K` A tiles from tile memory into the buffer slots. It then streams buffer slots to the tensor-core datapath over a valid/ready handshake, in the order needed for an M×N output sweep. It owns the buffer's `write_en`, `ptr_in` and `ptr_out`. Tile data flows directly from memory to the buffer and never passes through this block.

## Interface
- `ITER_M`, 4: A tile rows (M/TILE_M).
- `ITER_K`, 4: A tile columns (K/TILE_K).
- `DW_IDX`, 4: buffer slot index width; ITER_M*ITER_K ≤ 2^DW_IDX.
- `AW`, 16: tile-memory address width (tile granularity).
- `NW`, 8: width of the N-iteration count.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle job start; honoured only in IDLE.
- `cfg_base` in AW: tile-memory address of tile 0, latched on start.
- `cfg_iter_n` in NW: number of B column blocks (N/TILE_N), latched on start.
- `mem_req` out 1: tile read request.
- `mem_addr` out AW: `cfg_base + issue_cnt`.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid on the buffer's A_input. Returns are in request order.
- `buf_we` out 1: drives buffer write_en.
- `buf_ptr_in` out DW_IDX: write slot.
- `buf_ptr_out` out DW_IDX: read slot.
- `tile_valid` out 1: `A_tile` for `buf_ptr_out` is valid.
- `tile_ready` in 1: datapath accepts the tile.
- `tile_k_first` out 1: current tile has k==0 (datapath clears accumulator).
- `tile_k_last` out 1: current tile has k==ITER_K-1 (datapath writes C).
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse at job completion.

## Operation
- Let T = ITER_M*ITER_K. FSM states: IDLE, LOAD, STREAM, DONE.
- **IDLE → LOAD** on start. Latch cfg; clear issue_cnt, ret_cnt, m, n, k.
- **LOAD**:
  - `mem_req` is high while issue_cnt < T. issue_cnt increments on `mem_req & mem_gnt`. `mem_addr` is stable while req is high and ungranted.
  - Multiple reads may be outstanding.
  - On `mem_rvalid` (combinational pass-through): `buf_we=1`, `buf_ptr_in=ret_cnt`, then ret_cnt increments.
  - `mem_rvalid` with ret_cnt==T is a protocol error: ignore it and do not write.
  - Go to STREAM when ret_cnt reaches T (on the last write). If cfg_iter_n==0, go to DONE instead.
- **STREAM**:
  - Iteration order: m outer, n middle, k inner. `buf_ptr_out = m*ITER_K + k`.
  - `tile_valid=1` throughout. On `tile_valid & tile_ready`, advance k.
  - k wraps 0 after ITER_K-1 and carries into n. n wraps after cfg_iter_n-1 and carries into m.
  - After the handshake at (ITER_M-1, cfg_iter_n-1, ITER_K-1), go to DONE.
  - `tile_k_first = (k==0)`; `tile_k_last = (k==ITER_K-1)`.
- **DONE**: `done=1` for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `cfg_*` changes after start have no effect.

## Timing
- Reset values: state IDLE; all counters 0; mem_req, buf_we, tile_valid, tile_k_first, tile_k_last, busy, done = 0; mem_addr, buf_ptr_in, buf_ptr_out = 0.
- Reset mid-job aborts immediately. No further writes or tiles occur, and done is not pulsed.
- `mem_req` rises the cycle after start. `busy` rises the cycle after start and falls the cycle after done.
- Buffer writes are combinational from `mem_rvalid`. The buffer captures data on the same edge.
- Buffer read is combinational. `buf_ptr_out` is registered and updates the cycle after each handshake, so `A_tile` is valid in the same cycle as `tile_valid`.
- `tile_valid` rises the cycle after the last buffer write. The final write is therefore visible before the first read.
- With tile_ready held high: one tile per cycle, ITER_M*cfg_iter_n*ITER_K cycles of streaming. `done` follows in the next cycle.
- `tile_valid`, `buf_ptr_out` and the k flags are held stable while `tile_ready` is low.

## Test plan
- Default params, cfg_base=0x40, cfg_iter_n=1, gnt and rvalid 1 cycle after each req, ready=1:
  - mem_addr runs 0x40..0x4F.
  - buf_ptr_in runs 0..15.
  - buf_ptr_out runs 0..15 in order.
  - done pulses exactly once; busy falls the cycle after done.
- cfg_iter_n=2, ready=1 → buf_ptr_out sequence 0,1,2,3,0,1,2,3,4,5,6,7,4,5,6,7…; 32 handshakes; tile_k_last high on every 4th.
- Random mem_gnt stalls, 3 reads outstanding, random tile_ready → mem_addr is stable under stall; exactly 16 writes in slot order; outputs are held while not ready; checker reproduces the expected sequence.
- cfg_iter_n=0 → 16 writes, tile_valid never asserts, done pulses once after the last write.
- reset asserted at the 7th buffer write, then start again with cfg_base=0x80 → state returns to IDLE with all outputs 0; the second job reads 0x80..0x8F and completes normally.
- start pulsed during STREAM → ignored; the sequence is unchanged and done pulses once.
